sayeh_controller: RTL and testbench

- Multi-cycle control unit for the Sayeh 16-bit processor; the issuing end of the datapath control interface.
- Fetches instruction words over the memory handshake and decodes IR (fed back as Instruction) plus C/Z flags.
- Sequences every datapath strobe per instruction, including the packed low-byte "shadow" instruction.

---
 rtl/sayeh_ctrl_pkg.sv | 90 +++++++++
 rtl/sayeh_controller_decoder.sv | 124 ++++++++++++
 rtl/sayeh_controller.sv | 150 +++++++++++++++
 tb/tb_sayeh_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sayeh_ctrl_pkg.sv
// Shared types and encodings for the Sayeh control unit: sequencer states,
// opcode/sub-op values and the packed datapath control vector.
package sayeh_ctrl_pkg;

   localparam int OPW = 4;

   typedef enum logic [2:0] {
      ST_RST     = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXEC    = 3'd3,
      ST_MEMWAIT = 3'd4,
      ST_INCPC   = 3'd5,
      ST_HALT    = 3'd6
   } state_e;

   localparam logic [OPW-1:0] OP_CTL = 4'h0;
   localparam logic [OPW-1:0] OP_MVR = 4'h1;
   localparam logic [OPW-1:0] OP_LDA = 4'h2;
   localparam logic [OPW-1:0] OP_STA = 4'h3;
   localparam logic [OPW-1:0] OP_AND = 4'h5;
   localparam logic [OPW-1:0] OP_ORR = 4'h6;
   localparam logic [OPW-1:0] OP_NOT = 4'h7;
   localparam logic [OPW-1:0] OP_SHL = 4'h8;
   localparam logic [OPW-1:0] OP_SHR = 4'h9;
   localparam logic [OPW-1:0] OP_ADD = 4'hA;
   localparam logic [OPW-1:0] OP_SUB = 4'hB;
   localparam logic [OPW-1:0] OP_MUL = 4'hC;
   localparam logic [OPW-1:0] OP_CMP = 4'hD;
   localparam logic [OPW-1:0] OP_IMM = 4'hE;
   localparam logic [OPW-1:0] OP_BR  = 4'hF;

   localparam logic [OPW-1:0] CTL_NOP = 4'h0;
   localparam logic [OPW-1:0] CTL_HLT = 4'h1;
   localparam logic [OPW-1:0] CTL_SZF = 4'h2;
   localparam logic [OPW-1:0] CTL_CZF = 4'h3;
   localparam logic [OPW-1:0] CTL_SCF = 4'h4;
   localparam logic [OPW-1:0] CTL_CCF = 4'h5;
   localparam logic [OPW-1:0] CTL_CWP = 4'h6;

   localparam logic [1:0] IMM_MIL = 2'd0;
   localparam logic [1:0] IMM_MIH = 2'd1;
   localparam logic [1:0] IMM_SPC = 2'd2;
   localparam logic [1:0] IMM_JPA = 2'd3;

   localparam logic [OPW-1:0] BR_JPR = 4'h0;
   localparam logic [OPW-1:0] BR_BRZ = 4'h1;
   localparam logic [OPW-1:0] BR_BRC = 4'h2;
   localparam logic [OPW-1:0] BR_AWP = 4'h3;

   typedef struct packed {
      logic read_mem;
      logic write_mem;
      logic reset_pc;
      logic pc_plus_i;
      logic pc_plus_1;
      logic r_plus_i;
      logic r_plus_0;
      logic enable_pc;
      logic rs_on_r;
      logic rd_on_r;
      logic b15to0;
      logic a_and_b;
      logic a_or_b;
      logic not_b;
      logic shl_b;
      logic shr_b;
      logic a_add_b;
      logic a_sub_b;
      logic a_mul_b;
      logic a_cmp_b;
      logic rfl_write;
      logic rfh_write;
      logic wp_reset;
      logic wp_add;
      logic ir_load;
      logic sr_load;
      logic addr_on_db;
      logic alu_on_db;
      logic ir_on_lopnd;
      logic ir_on_hopnd;
      logic rfright_on_opnd;
      logic c_set;
      logic c_reset;
      logic z_set;
      logic z_reset;
      logic shadow;
   } ctrl_t;

endpackage

// File: rtl/sayeh_controller_decoder.sv
// Combinational decode of one instruction half (opcode + sub nibble) into the
// datapath control vector plus the sequencing hints the top FSM needs.
module sayeh_decoder
   import sayeh_ctrl_pkg::*;
(
   input  logic [OPW-1:0] opcode_i,
   input  logic [OPW-1:0] sub_i,
   input  logic           main_i,
   input  logic           zout_i,
   input  logic           cout_i,
   output ctrl_t          ctrl_o,
   output logic           mem_rd_o,
   output logic           mem_wr_o,
   output logic           halt_o,
   output logic           jump_o,
   output logic           whole_o
);

   logic alu_op_s;
   logic reg_wr_s;

   // Opcode table; whole-word formats only decode in the main half.
   always_comb begin
      ctrl_o   = '0;
      mem_rd_o = 1'b0;
      mem_wr_o = 1'b0;
      halt_o   = 1'b0;
      jump_o   = 1'b0;
      whole_o  = 1'b0;
      alu_op_s = 1'b0;
      reg_wr_s = 1'b0;
      case (opcode_i)
         OP_CTL: begin
            case (sub_i)
               CTL_NOP: halt_o = 1'b0;
               CTL_HLT: halt_o = 1'b1;
               CTL_SZF: ctrl_o.z_set = 1'b1;
               CTL_CZF: ctrl_o.z_reset = 1'b1;
               CTL_SCF: ctrl_o.c_set = 1'b1;
               CTL_CCF: ctrl_o.c_reset = 1'b1;
               CTL_CWP: ctrl_o.wp_reset = 1'b1;
               default: halt_o = 1'b0;
            endcase
         end
         OP_MVR: begin
            ctrl_o.b15to0          = 1'b1;
            ctrl_o.rfright_on_opnd = 1'b1;
            ctrl_o.alu_on_db       = 1'b1;
            reg_wr_s               = 1'b1;
         end
         OP_LDA: begin
            ctrl_o.r_plus_0 = 1'b1;
            ctrl_o.rs_on_r  = 1'b1;
            mem_rd_o        = 1'b1;
            reg_wr_s        = 1'b1;
         end
         OP_STA: begin
            ctrl_o.r_plus_0        = 1'b1;
            ctrl_o.rd_on_r         = 1'b1;
            ctrl_o.rfright_on_opnd = 1'b1;
            ctrl_o.b15to0          = 1'b1;
            ctrl_o.alu_on_db       = 1'b1;
            mem_wr_o               = 1'b1;
         end
         OP_AND: begin ctrl_o.a_and_b = 1'b1; alu_op_s = 1'b1; reg_wr_s = 1'b1; end
         OP_ORR: begin ctrl_o.a_or_b  = 1'b1; alu_op_s = 1'b1; reg_wr_s = 1'b1; end
         OP_NOT: begin ctrl_o.not_b   = 1'b1; alu_op_s = 1'b1; reg_wr_s = 1'b1; end
         OP_SHL: begin ctrl_o.shl_b   = 1'b1; alu_op_s = 1'b1; reg_wr_s = 1'b1; end
         OP_SHR: begin ctrl_o.shr_b   = 1'b1; alu_op_s = 1'b1; reg_wr_s = 1'b1; end
         OP_ADD: begin ctrl_o.a_add_b = 1'b1; alu_op_s = 1'b1; reg_wr_s = 1'b1; end
         OP_SUB: begin ctrl_o.a_sub_b = 1'b1; alu_op_s = 1'b1; reg_wr_s = 1'b1; end
         OP_MUL: begin ctrl_o.a_mul_b = 1'b1; alu_op_s = 1'b1; reg_wr_s = 1'b1; end
         OP_CMP: begin ctrl_o.a_cmp_b = 1'b1; alu_op_s = 1'b1; end
         OP_IMM: begin
            whole_o = main_i;
            case (sub_i[1:0])
               IMM_MIL: begin
                  ctrl_o.ir_on_lopnd = main_i;
                  ctrl_o.b15to0      = main_i;
                  ctrl_o.rfl_write   = main_i;
               end
               IMM_MIH: begin
                  ctrl_o.ir_on_hopnd = main_i;
                  ctrl_o.b15to0      = main_i;
                  ctrl_o.rfh_write   = main_i;
               end
               IMM_SPC: begin
                  ctrl_o.addr_on_db = main_i;
                  ctrl_o.rfl_write  = main_i;
                  ctrl_o.rfh_write  = main_i;
               end
               IMM_JPA: begin
                  ctrl_o.r_plus_i  = main_i;
                  ctrl_o.rd_on_r   = main_i;
                  ctrl_o.enable_pc = main_i;
                  jump_o           = main_i;
               end
               default: jump_o = 1'b0;
            endcase
         end
         OP_BR: begin
            whole_o = main_i;
            case (sub_i)
               BR_JPR:  jump_o = main_i;
               BR_BRZ:  jump_o = main_i & zout_i;
               BR_BRC:  jump_o = main_i & cout_i;
               BR_AWP:  ctrl_o.wp_add = main_i;
               default: jump_o = 1'b0;
            endcase
            ctrl_o.pc_plus_i = jump_o;
            ctrl_o.enable_pc = jump_o;
         end
         default: halt_o = 1'b0;
      endcase
      ctrl_o.rfright_on_opnd = ctrl_o.rfright_on_opnd | alu_op_s;
      ctrl_o.alu_on_db       = ctrl_o.alu_on_db | alu_op_s;
      ctrl_o.sr_load         = alu_op_s;
      ctrl_o.rfl_write       = ctrl_o.rfl_write | reg_wr_s;
      ctrl_o.rfh_write       = ctrl_o.rfh_write | reg_wr_s;
      ctrl_o.read_mem        = mem_rd_o;
      ctrl_o.write_mem       = mem_wr_o;
   end

endmodule

// File: rtl/sayeh_controller.sv
// Sayeh multi-cycle control unit: fetch/decode/execute sequencer that drives
// every datapath strobe, executing the packed low-byte shadow instruction too.
module sayeh_controller
   import sayeh_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        ExternalReset,
   input  logic [15:0] Instruction,
   input  logic        Cout,
   input  logic        Zout,
   input  logic        MemDataready,
   output logic        ReadMem, WriteMem,
   output logic        ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC,
   output logic        Rs_on_AddressUnitRSide, Rd_on_AddressUnitRSide,
   output logic        B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB,
   output logic        RFLwrite, RFHwrite, WPreset, WPadd, IRload, SRload,
   output logic        Address_on_Databus, ALU_on_Databus, IR_on_LOpndBus, IR_on_HOpndBus,
   output logic        RFright_on_OpndBus,
   output logic        Cset, Creset, Zset, Zreset, Shadow
);

   state_e         state_q;
   logic           shadow_q;
   logic [OPW-1:0] opcode_s;
   logic [OPW-1:0] sub_s;
   ctrl_t          dec_s;
   ctrl_t          ctrl_s;
   logic           mem_rd_s, mem_wr_s, halt_s, jump_s, whole_s;
   logic           mem_done_s;
   logic           has_shadow_s;

   assign opcode_s = shadow_q ? Instruction[7:4] : Instruction[15:12];
   assign sub_s    = shadow_q ? Instruction[3:0] : Instruction[11:8];

   sayeh_decoder u_decoder (
      .opcode_i (opcode_s),
      .sub_i    (sub_s),
      .main_i   (~shadow_q),
      .zout_i   (Zout),
      .cout_i   (Cout),
      .ctrl_o   (dec_s),
      .mem_rd_o (mem_rd_s),
      .mem_wr_o (mem_wr_s),
      .halt_o   (halt_s),
      .jump_o   (jump_s),
      .whole_o  (whole_s)
   );

   assign mem_done_s   = ~(mem_rd_s | mem_wr_s) | MemDataready;
   assign has_shadow_s = ~shadow_q & ~whole_s & (Instruction[7:0] != 8'h00);

   // Instruction sequencer; EXEC doubles as the first cycle of a memory access.
   always_ff @(posedge clk) begin
      if (ExternalReset) begin
         state_q  <= ST_RST;
         shadow_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RST:    state_q <= ST_FETCH;
            ST_FETCH:  state_q <= MemDataready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
               state_q  <= ST_EXEC;
               shadow_q <= 1'b0;
            end
            ST_EXEC, ST_MEMWAIT: begin
               if (!mem_done_s) begin
                  state_q <= ST_MEMWAIT;
               end else if (halt_s) begin
                  state_q <= ST_HALT;
               end else if (jump_s) begin
                  state_q <= ST_FETCH;
               end else if (has_shadow_s) begin
                  state_q  <= ST_EXEC;
                  shadow_q <= 1'b1;
               end else begin
                  state_q <= ST_INCPC;
               end
            end
            ST_INCPC:  state_q <= ST_FETCH;
            ST_HALT:   state_q <= ST_HALT;
            default:   state_q <= ST_RST;
         endcase
      end
   end

   // Output decode from state; a load writes its register on the completing cycle.
   always_comb begin
      ctrl_s = '0;
      case (state_q)
         ST_RST: begin
            ctrl_s.reset_pc  = 1'b1;
            ctrl_s.enable_pc = 1'b1;
            ctrl_s.wp_reset  = 1'b1;
         end
         ST_FETCH: begin
            ctrl_s.read_mem = 1'b1;
            ctrl_s.ir_load  = MemDataready;
         end
         ST_EXEC, ST_MEMWAIT: begin
            ctrl_s           = dec_s;
            ctrl_s.shadow    = shadow_q;
            ctrl_s.rfl_write = dec_s.rfl_write & (~mem_rd_s | MemDataready);
            ctrl_s.rfh_write = dec_s.rfh_write & (~mem_rd_s | MemDataready);
         end
         ST_INCPC: begin
            ctrl_s.pc_plus_1 = 1'b1;
            ctrl_s.enable_pc = 1'b1;
         end
         default: ctrl_s = '0;
      endcase
   end

   assign ReadMem                = ctrl_s.read_mem;
   assign WriteMem               = ctrl_s.write_mem;
   assign ResetPC                = ctrl_s.reset_pc;
   assign PCplusI                = ctrl_s.pc_plus_i;
   assign PCplus1                = ctrl_s.pc_plus_1;
   assign RplusI                 = ctrl_s.r_plus_i;
   assign Rplus0                 = ctrl_s.r_plus_0;
   assign EnablePC               = ctrl_s.enable_pc;
   assign Rs_on_AddressUnitRSide = ctrl_s.rs_on_r;
   assign Rd_on_AddressUnitRSide = ctrl_s.rd_on_r;
   assign B15to0                 = ctrl_s.b15to0;
   assign AandB                  = ctrl_s.a_and_b;
   assign AorB                   = ctrl_s.a_or_b;
   assign notB                   = ctrl_s.not_b;
   assign shlB                   = ctrl_s.shl_b;
   assign shrB                   = ctrl_s.shr_b;
   assign AaddB                  = ctrl_s.a_add_b;
   assign AsubB                  = ctrl_s.a_sub_b;
   assign AmulB                  = ctrl_s.a_mul_b;
   assign AcmpB                  = ctrl_s.a_cmp_b;
   assign RFLwrite               = ctrl_s.rfl_write;
   assign RFHwrite               = ctrl_s.rfh_write;
   assign WPreset                = ctrl_s.wp_reset;
   assign WPadd                  = ctrl_s.wp_add;
   assign IRload                 = ctrl_s.ir_load;
   assign SRload                 = ctrl_s.sr_load;
   assign Address_on_Databus     = ctrl_s.addr_on_db;
   assign ALU_on_Databus         = ctrl_s.alu_on_db;
   assign IR_on_LOpndBus         = ctrl_s.ir_on_lopnd;
   assign IR_on_HOpndBus         = ctrl_s.ir_on_hopnd;
   assign RFright_on_OpndBus     = ctrl_s.rfright_on_opnd;
   assign Cset                   = ctrl_s.c_set;
   assign Creset                 = ctrl_s.c_reset;
   assign Zset                   = ctrl_s.z_set;
   assign Zreset                 = ctrl_s.z_reset;
   assign Shadow                 = ctrl_s.shadow;

endmodule

// File: tb/tb_sayeh_controller.sv
// Bench for sayeh_controller: builds the expected per-cycle strobe trace of each
// instruction from the ISA rules and compares it against the DUT outputs.
module tb_sayeh_controller;

   logic        clk;
   logic        ExternalReset, Cout, Zout, MemDataready;
   logic [15:0] Instruction;
   logic ReadMem, WriteMem, ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC;
   logic Rs_on_AddressUnitRSide, Rd_on_AddressUnitRSide;
   logic B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB;
   logic RFLwrite, RFHwrite, WPreset, WPadd, IRload, SRload;
   logic Address_on_Databus, ALU_on_Databus, IR_on_LOpndBus, IR_on_HOpndBus, RFright_on_OpndBus;
   logic Cset, Creset, Zset, Zreset, Shadow;

   int n_checks = 0;
   int n_fail   = 0;

   sayeh_controller dut (
      .clk(clk), .ExternalReset(ExternalReset), .Instruction(Instruction),
      .Cout(Cout), .Zout(Zout), .MemDataready(MemDataready),
      .ReadMem(ReadMem), .WriteMem(WriteMem), .ResetPC(ResetPC), .PCplusI(PCplusI),
      .PCplus1(PCplus1), .RplusI(RplusI), .Rplus0(Rplus0), .EnablePC(EnablePC),
      .Rs_on_AddressUnitRSide(Rs_on_AddressUnitRSide), .Rd_on_AddressUnitRSide(Rd_on_AddressUnitRSide),
      .B15to0(B15to0), .AandB(AandB), .AorB(AorB), .notB(notB), .shlB(shlB), .shrB(shrB),
      .AaddB(AaddB), .AsubB(AsubB), .AmulB(AmulB), .AcmpB(AcmpB),
      .RFLwrite(RFLwrite), .RFHwrite(RFHwrite), .WPreset(WPreset), .WPadd(WPadd),
      .IRload(IRload), .SRload(SRload), .Address_on_Databus(Address_on_Databus),
      .ALU_on_Databus(ALU_on_Databus), .IR_on_LOpndBus(IR_on_LOpndBus),
      .IR_on_HOpndBus(IR_on_HOpndBus), .RFright_on_OpndBus(RFright_on_OpndBus),
      .Cset(Cset), .Creset(Creset), .Zset(Zset), .Zreset(Zreset), .Shadow(Shadow)
   );

   localparam int RDM = 0,  WRM = 1,  RPC = 2,  PCI = 3,  PC1 = 4,  RPI = 5,  RP0 = 6;
   localparam int ENPC = 7, RSR = 8,  RDR = 9,  B15 = 10;
   localparam int RFL = 20, RFH = 21, WPR = 22, WPA = 23, IRL = 24, SRL = 25, ADB = 26;
   localparam int ALUDB = 27, IRLO = 28, IRHO = 29, RFR = 30;
   localparam int CST = 31, CRS = 32, ZST = 33, ZRS = 34, SHD = 35;

   logic [35:0] obs_s;
   assign obs_s = {Shadow, Zreset, Zset, Creset, Cset, RFright_on_OpndBus, IR_on_HOpndBus,
                   IR_on_LOpndBus, ALU_on_Databus, Address_on_Databus, SRload, IRload, WPadd,
                   WPreset, RFHwrite, RFLwrite, AcmpB, AmulB, AsubB, AaddB, shrB, shlB, notB,
                   AorB, AandB, B15to0, Rd_on_AddressUnitRSide, Rs_on_AddressUnitRSide,
                   EnablePC, Rplus0, RplusI, PCplus1, PCplusI, ResetPC, WriteMem, ReadMem};

   typedef struct packed {
      logic [35:0] vec;
      logic        mem_rd;
      logic        mem_wr;
      logic        halt;
      logic        jump;
      logic        whole;
   } half_t;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [35:0] one(input int i);
      return 36'd1 << i;
   endfunction

   // Reference behaviour of one instruction half, straight from the ISA table.
   function automatic half_t model_half(input logic [3:0] op, input logic [3:0] sub,
                                        input logic main, input logic z, input logic c);
      half_t h;
      logic  taken;
      h = '0;
      if (op == 4'd0) begin
         case (sub)
            4'd1: h.halt = 1'b1;
            4'd2: h.vec[ZST] = 1'b1;
            4'd3: h.vec[ZRS] = 1'b1;
            4'd4: h.vec[CST] = 1'b1;
            4'd5: h.vec[CRS] = 1'b1;
            4'd6: h.vec[WPR] = 1'b1;
            default: h.halt = 1'b0;
         endcase
      end else if (op == 4'd1) begin
         h.vec = one(B15) | one(RFR) | one(ALUDB) | one(RFL) | one(RFH);
      end else if (op == 4'd2) begin
         h.vec = one(RP0) | one(RSR) | one(RDM) | one(RFL) | one(RFH);
         h.mem_rd = 1'b1;
      end else if (op == 4'd3) begin
         h.vec = one(RP0) | one(RDR) | one(RFR) | one(B15) | one(ALUDB) | one(WRM);
         h.mem_wr = 1'b1;
      end else if (op >= 4'd5 && op <= 4'd13) begin
         h.vec = one(int'(op) + 6) | one(RFR) | one(ALUDB) | one(SRL);
         if (op != 4'd13) h.vec = h.vec | one(RFL) | one(RFH);
      end else if (op == 4'd14 && main) begin
         h.whole = 1'b1;
         case (sub[1:0])
            2'd0: h.vec = one(IRLO) | one(B15) | one(RFL);
            2'd1: h.vec = one(IRHO) | one(B15) | one(RFH);
            2'd2: h.vec = one(ADB) | one(RFL) | one(RFH);
            default: begin
               h.vec  = one(RPI) | one(RDR) | one(ENPC);
               h.jump = 1'b1;
            end
         endcase
      end else if (op == 4'd15 && main) begin
         h.whole = 1'b1;
         taken = (sub == 4'd0) || (sub == 4'd1 && z) || (sub == 4'd2 && c);
         if (taken) begin
            h.vec  = one(PCI) | one(ENPC);
            h.jump = 1'b1;
         end
         if (sub == 4'd3) h.vec = one(WPA);
      end
      return h;
   endfunction

   task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic rdy, input logic [35:0] e, input string tag);
      MemDataready = rdy;
      @(negedge clk);
      check_eq(tag, obs_s, e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int ncyc);
      ExternalReset = 1'b1;
      MemDataready  = 1'b0;
      repeat (ncyc) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("reset", obs_s, one(RPC) | one(ENPC) | one(WPR));
      end
      ExternalReset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [15:0] w, input logic z, input logic c,
                            input int fwait, input int mwait, output logic halted);
      half_t       h;
      logic [35:0] e;
      logic [3:0]  op, sub;
      halted = 1'b0;
      Zout   = z;
      Cout   = c;
      for (int i = 0; i < fwait; i++) step(1'b0, one(RDM), "fetch_wait");
      Instruction = w;
      step(1'b1, one(RDM) | one(IRL), "fetch_done");
      step(1'b0, '0, "decode");
      for (int hf = 0; hf < 2; hf++) begin
         op  = (hf == 0) ? w[15:12] : w[7:4];
         sub = (hf == 0) ? w[11:8]  : w[3:0];
         h   = model_half(op, sub, hf == 0, z, c);
         if (hf == 1) h.vec[SHD] = 1'b1;
         if (h.mem_rd || h.mem_wr) begin
            e = h.vec;
            if (h.mem_rd) begin
               e[RFL] = 1'b0;
               e[RFH] = 1'b0;
            end
            for (int i = 0; i < mwait; i++) step(1'b0, e, "mem_wait");
            step(1'b1, h.vec, "mem_done");
         end else begin
            step(1'($urandom_range(0, 1)), h.vec, "exec");
         end
         if (h.halt) begin
            halted = 1'b1;
            return;
         end
         if (h.jump) return;
         if (hf == 1 || h.whole || w[7:0] == 8'h00) break;
      end
      step(1'($urandom_range(0, 1)), one(PC1) | one(ENPC), "incpc");
   endtask

   task automatic halt_then_reset(input int n);
      for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), '0, "halt");
      do_reset(1);
   endtask

   initial begin
      logic        halted;
      logic [15:0] w;
      ExternalReset = 1'b1;
      MemDataready  = 1'b0;
      Instruction   = 16'h0000;
      Zout          = 1'b0;
      Cout          = 1'b0;
      do_reset(2);

      run_instr(16'h5A00, 1'b0, 1'b0, 0, 0, halted);
      run_instr(16'h1B02, 1'b0, 1'b0, 1, 0, halted);
      run_instr(16'hF105, 1'b1, 1'b0, 0, 0, halted);
      run_instr(16'hF105, 1'b0, 1'b0, 0, 0, halted);
      run_instr(16'h2400, 1'b0, 1'b0, 0, 3, halted);
      run_instr(16'h3100, 1'b0, 1'b0, 0, 2, halted);
      run_instr(16'h0100, 1'b0, 1'b0, 0, 0, halted);
      if (halted) halt_then_reset(10);
      else check_eq("halt_entry", 36'd0, 36'd1);

      // reset abandons an outstanding load
      Instruction = 16'h2400;
      step(1'b1, one(RDM) | one(IRL), "fetch_done");
      step(1'b0, '0, "decode");
      step(1'b0, one(RDM) | one(RP0) | one(RSR), "lda_hold");
      step(1'b0, one(RDM) | one(RP0) | one(RSR), "lda_hold");
      do_reset(1);

      for (int n = 0; n < 200; n++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 1) == 0) w[7:0] = 8'h00;
         if (w[15:12] == 4'h0 && w[11] == 1'b1) w[11] = 1'b0;
         run_instr(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), halted);
         if (halted) halt_then_reset(3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
